// File: rtl/dcache_mshr.sv
// Dcache load-miss MSHRs: allocate on miss, issue line LOADs to memory, match tagged returns into a registered fill bus.
// Fill is 1 cycle after data return; misses are dropped while mshr_stall_o is high. Define DCACHE_MSHR_MERGE_EN to merge same-line misses.
module dcache_mshr #(
  parameter int MSHR_NUM  = 4,
  parameter int ADDR_W    = 64,
  parameter int MEM_TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_en_i,
  input  logic [ADDR_W-1:0]    miss_addr_i,
  output logic                 mshr_stall_o,
  input  logic                 mem_gnt_i,
  output logic [1:0]           proc2mem_command_o,
  output logic [ADDR_W-1:0]    proc2mem_addr_o,
  input  logic [MEM_TAG_W-1:0] mem2proc_response_i,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag_i,
  input  logic [63:0]          mem2proc_data_i,
  output logic                 fill_vld_o,
  output logic [ADDR_W-1:0]    fill_addr_o,
  output logic [63:0]          fill_data_o
);
  localparam int LINE_W = ADDR_W - 3;
  localparam int IDX_W  = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {
    ST_INVALID    = 2'd0,
    ST_WAIT_ISSUE = 2'd1,
    ST_WAIT_DATA  = 2'd2
  } state_e;

  state_e                st_q   [MSHR_NUM];
  state_e                st_d   [MSHR_NUM];
  logic [LINE_W-1:0]     line_q [MSHR_NUM];
  logic [LINE_W-1:0]     line_d [MSHR_NUM];
  logic [MEM_TAG_W-1:0]  tag_q  [MSHR_NUM];
  logic [MEM_TAG_W-1:0]  tag_d  [MSHR_NUM];
  logic                  fill_vld_q, fill_vld_d;
  logic [ADDR_W-1:0]     fill_addr_q, fill_addr_d;
  logic [63:0]           fill_data_q, fill_data_d;

  logic                  free_found, cand_found, fill_hit, merge_hit;
  logic [IDX_W-1:0]      free_idx, cand_idx, fill_idx;
  logic                  issue, alloc;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^miss_addr_i[2:0];

  // Descending scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    fill_hit   = 1'b0;
    fill_idx   = '0;
    merge_hit  = 1'b0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (st_q[i] == ST_INVALID) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (st_q[i] == ST_WAIT_ISSUE) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
      end
      if (st_q[i] == ST_WAIT_DATA && mem2proc_tag_i != '0 && tag_q[i] == mem2proc_tag_i) begin
        fill_hit = 1'b1;
        fill_idx = IDX_W'(i);
      end
`ifdef DCACHE_MSHR_MERGE_EN
      if (st_q[i] != ST_INVALID && line_q[i] == miss_addr_i[ADDR_W-1:3]) begin
        merge_hit = 1'b1;
      end
`endif
    end
  end

  assign mshr_stall_o       = ~free_found;
  assign issue              = cand_found & mem_gnt_i;
  assign alloc              = miss_en_i & ~mshr_stall_o & ~merge_hit;
  assign proc2mem_command_o = issue ? CMD_LOAD : CMD_NONE;
  assign proc2mem_addr_o    = issue ? {line_q[cand_idx], 3'b000} : '0;

  // Fill, issue and allocate always touch distinct entries (different source states).
  always_comb begin
    st_d        = st_q;
    line_d      = line_q;
    tag_d       = tag_q;
    fill_vld_d  = fill_hit;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    if (fill_hit) begin
      st_d[fill_idx] = ST_INVALID;
      fill_addr_d    = {line_q[fill_idx], 3'b000};
      fill_data_d    = mem2proc_data_i;
    end
    if (issue && mem2proc_response_i != '0) begin
      st_d[cand_idx]  = ST_WAIT_DATA;
      tag_d[cand_idx] = mem2proc_response_i;
    end
    if (alloc) begin
      st_d[free_idx]   = ST_WAIT_ISSUE;
      line_d[free_idx] = miss_addr_i[ADDR_W-1:3];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MSHR_NUM; i++) begin
        st_q[i]   <= ST_INVALID;
        line_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      fill_vld_q  <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      st_q        <= st_d;
      line_q      <= line_d;
      tag_q       <= tag_d;
      fill_vld_q  <= fill_vld_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign fill_vld_o  = fill_vld_q;
  assign fill_addr_o = fill_addr_q;
  assign fill_data_o = fill_data_q;
endmodule
